// File: rtl/fp_addsub_requester_if.sv
// Host command/response channels and engine bus of the FP add/sub requester.
// master = requester side, slave = host plus engine side.
interface fp_addsub_requester_if;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [31:0] cmd_op1;
   logic [31:0] cmd_op2;
   logic        cmd_mode;
   logic        add_start;
   logic        mode;
   logic [31:0] op1;
   logic [31:0] op2;
   logic [31:0] add_result;
   logic        add_done;
   logic        add_overflow;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_result;
   logic        rsp_overflow;
   logic        rsp_timeout;

   modport master (
      input  cmd_valid, cmd_op1, cmd_op2, cmd_mode,
      output cmd_ready,
      output add_start, mode, op1, op2,
      input  add_result, add_done, add_overflow,
      output rsp_valid, rsp_result, rsp_overflow, rsp_timeout,
      input  rsp_ready
   );

   modport slave (
      output cmd_valid, cmd_op1, cmd_op2, cmd_mode,
      input  cmd_ready,
      input  add_start, mode, op1, op2,
      output add_result, add_done, add_overflow,
      input  rsp_valid, rsp_result, rsp_overflow, rsp_timeout,
      output rsp_ready
   );
endinterface

// File: rtl/fp_addsub_requester.sv
// Initiator for the FP add/sub engine: one operation in flight, zero operands
// answered locally, engine operations bounded by a timeout.
module fp_addsub_requester #(
   parameter int unsigned MIN_LAT = 1,
   parameter int unsigned TIMEOUT = 64,
   parameter int unsigned CNT_W   = 16
) (
   input  logic                  clk,
   input  logic                  n_rst,
   fp_addsub_requester_if.master bus,
   output logic [CNT_W-1:0]      op_count
);

   localparam int unsigned WAIT_W = $clog2(TIMEOUT);

   typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

   state_e             state_q, state_d;
   logic [WAIT_W-1:0]  cnt_q, cnt_d;
   logic [31:0]        op1_q, op1_d, op2_q, op2_d;
   logic               mode_q, mode_d;
   logic [31:0]        res_q, res_d;
   logic               ovf_q, ovf_d;
   logic               tmo_q, tmo_d;
   logic [CNT_W-1:0]   count_q, count_d;
   logic               alive_q;
   logic               op1_zero, op2_zero;
   logic               done_ok, timed_out;

   // Exponent of zero covers denormals, which are flushed to zero here.
   assign op1_zero = (bus.cmd_op1[30:23] == 8'h00);
   assign op2_zero = (bus.cmd_op2[30:23] == 8'h00);

   // cnt_q counts completed WAIT cycles, so cnt_q + 1 is the current WAIT cycle.
   assign done_ok   = bus.add_done && ((32'(cnt_q) + 32'd1) >= MIN_LAT);
   assign timed_out = (cnt_q == WAIT_W'(TIMEOUT - 1));

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      op1_d   = op1_q;
      op2_d   = op2_q;
      mode_d  = mode_q;
      res_d   = res_q;
      ovf_d   = ovf_q;
      tmo_d   = tmo_q;
      count_d = count_q;
      unique case (state_q)
         StIdle: begin
            if (bus.cmd_valid && alive_q) begin
               op1_d  = bus.cmd_op1;
               op2_d  = bus.cmd_op2;
               mode_d = bus.cmd_mode;
               res_d  = 32'h0000_0000;
               ovf_d  = 1'b0;
               tmo_d  = 1'b0;
               if (op1_zero && op2_zero) begin
                  state_d = StResp;
               end else if (op2_zero) begin
                  res_d   = bus.cmd_op1;
                  state_d = StResp;
               end else if (op1_zero) begin
                  res_d   = {bus.cmd_op2[31] ^ bus.cmd_mode, bus.cmd_op2[30:0]};
                  state_d = StResp;
               end else begin
                  state_d = StIssue;
               end
            end
         end
         StIssue: begin
            cnt_d   = '0;
            state_d = StWait;
         end
         StWait: begin
            if (done_ok) begin
               res_d   = bus.add_result;
               ovf_d   = bus.add_overflow;
               tmo_d   = 1'b0;
               state_d = StResp;
            end else if (timed_out) begin
               res_d   = 32'h7FC0_0000;
               ovf_d   = 1'b0;
               tmo_d   = 1'b1;
               state_d = StResp;
            end else begin
               cnt_d = cnt_q + WAIT_W'(1);
            end
         end
         StResp: begin
            if (bus.rsp_ready) begin
               count_d = count_q + CNT_W'(1);
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         op1_q   <= '0;
         op2_q   <= '0;
         mode_q  <= 1'b0;
         res_q   <= '0;
         ovf_q   <= 1'b0;
         tmo_q   <= 1'b0;
         count_q <= '0;
         alive_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         op1_q   <= op1_d;
         op2_q   <= op2_d;
         mode_q  <= mode_d;
         res_q   <= res_d;
         ovf_q   <= ovf_d;
         tmo_q   <= tmo_d;
         count_q <= count_d;
         alive_q <= 1'b1;
      end
   end

   // alive_q keeps cmd_ready low until the first clock after reset release.
   assign bus.cmd_ready    = alive_q && (state_q == StIdle);
   assign bus.add_start    = (state_q == StIssue);
   assign bus.mode         = mode_q;
   assign bus.op1          = op1_q;
   assign bus.op2          = op2_q;
   assign bus.rsp_valid    = (state_q == StResp);
   assign bus.rsp_result   = res_q;
   assign bus.rsp_overflow = ovf_q;
   assign bus.rsp_timeout  = tmo_q;
   assign op_count         = count_q;

endmodule

// File: tb/tb_fp_addsub_requester.sv
// Bench for fp_addsub_requester: directed and random commands against a
// response/latency model, plus a MIN_LAT=3 instance with add_done tied high.
module tb_fp_addsub_requester;

   localparam int unsigned TMO = 16;

   logic clk = 1'b0;
   logic n_rst = 1'b0;
   always #5 clk = ~clk;

   fp_addsub_requester_if h ();
   fp_addsub_requester_if h3 ();
   logic [15:0] op_count, op_count3;

   fp_addsub_requester #(.MIN_LAT(1), .TIMEOUT(TMO), .CNT_W(16)) dut (
      .clk      (clk),
      .n_rst    (n_rst),
      .bus      (h.master),
      .op_count (op_count)
   );

   fp_addsub_requester #(.MIN_LAT(3), .TIMEOUT(TMO), .CNT_W(16)) dut3 (
      .clk      (clk),
      .n_rst    (n_rst),
      .bus      (h3.master),
      .op_count (op_count3)
   );

   // Engine stub: add_done rises eng_delay cycles into WAIT and stays high.
   logic        eng_busy = 1'b0;
   int          eng_cnt = 0;
   int          eng_delay = 0;
   logic [31:0] eng_word = '0;
   logic        eng_ovf = 1'b0;
   always @(posedge clk) begin
      if (h.add_start) begin
         eng_busy <= 1'b1;
         eng_cnt  <= 0;
      end else if (eng_busy) begin
         eng_cnt <= eng_cnt + 1;
      end
   end
   assign h.add_done     = eng_busy && (eng_cnt >= eng_delay);
   assign h.add_result   = eng_word;
   assign h.add_overflow = eng_ovf;

   assign h3.add_done     = 1'b1;
   assign h3.add_result   = 32'h1234_5678;
   assign h3.add_overflow = 1'b1;

   int compared = 0;
   int mismatched = 0;
   int exp_cnt = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic bit is_zero(input logic [31:0] x);
      return x[30:23] == 8'h00;
   endfunction

   task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic m,
                        input int delay, input int bp);
      logic [31:0] exp_res;
      logic        exp_ovf, exp_tmo, busy_rdy, opbad, unstable;
      int          exp_lat, exp_starts, n, starts, k;
      logic [31:0] hold_res;
      eng_word = $urandom;
      eng_ovf  = 1'($urandom_range(0, 1));
      eng_delay = delay;
      exp_ovf = 1'b0;
      exp_tmo = 1'b0;
      exp_starts = 0;
      exp_lat = 1;
      if (is_zero(a) && is_zero(b)) exp_res = 32'h0;
      else if (is_zero(b)) exp_res = a;
      else if (is_zero(a)) exp_res = {b[31] ^ m, b[30:0]};
      else begin
         exp_starts = 1;
         k = (delay > int'(TMO) - 1) ? int'(TMO) - 1 : delay;
         exp_lat = 3 + k;
         if (delay > int'(TMO) - 1) begin
            exp_res = 32'h7FC0_0000;
            exp_tmo = 1'b1;
         end else begin
            exp_res = eng_word;
            exp_ovf = eng_ovf;
         end
      end
      @(negedge clk);
      chk("cmd_ready_idle", {31'b0, h.cmd_ready}, 32'd1);
      h.cmd_op1 = a;
      h.cmd_op2 = b;
      h.cmd_mode = m;
      h.cmd_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      h.cmd_valid = 1'b0;
      n = 1;
      starts = 0;
      busy_rdy = 1'b0;
      opbad = 1'b0;
      while (!h.rsp_valid && n < 400) begin
         if (h.add_start) begin
            starts++;
            if (h.op1 !== a || h.op2 !== b || h.mode !== m) opbad = 1'b1;
         end
         busy_rdy |= h.cmd_ready;
         @(negedge clk);
         n++;
      end
      chk("latency", n, exp_lat);
      chk("rsp_result", h.rsp_result, exp_res);
      chk("rsp_overflow", {31'b0, h.rsp_overflow}, {31'b0, exp_ovf});
      chk("rsp_timeout", {31'b0, h.rsp_timeout}, {31'b0, exp_tmo});
      chk("engine_operands", {31'b0, opbad}, 32'd0);
      hold_res = h.rsp_result;
      unstable = 1'b0;
      for (int i = 0; i < bp; i++) begin
         @(negedge clk);
         if (h.rsp_valid !== 1'b1 || h.rsp_result !== hold_res) unstable = 1'b1;
         if (h.add_start) starts++;
         busy_rdy |= h.cmd_ready;
         if (op_count !== 16'(exp_cnt)) unstable = 1'b1;
      end
      if (bp > 0) chk("backpressure_stable", {31'b0, unstable}, 32'd0);
      chk("add_start_pulses", starts, exp_starts);
      chk("cmd_ready_busy", {31'b0, busy_rdy}, 32'd0);
      h.rsp_ready = 1'b1;
      @(negedge clk);
      h.rsp_ready = 1'b0;
      exp_cnt++;
      chk("rsp_valid_drop", {31'b0, h.rsp_valid}, 32'd0);
      chk("op_count", {16'b0, op_count}, 32'(exp_cnt));
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: observed no finish, required finish within time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int n;
      logic [31:0] a, b;
      h.cmd_valid = 1'b0;
      h.cmd_op1 = '0;
      h.cmd_op2 = '0;
      h.cmd_mode = 1'b0;
      h.rsp_ready = 1'b0;
      h3.cmd_valid = 1'b0;
      h3.cmd_op1 = '0;
      h3.cmd_op2 = '0;
      h3.cmd_mode = 1'b0;
      h3.rsp_ready = 1'b1;

      repeat (2) @(negedge clk);
      chk("rst_cmd_ready", {31'b0, h.cmd_ready}, 32'd0);
      chk("rst_add_start", {31'b0, h.add_start}, 32'd0);
      chk("rst_rsp_valid", {31'b0, h.rsp_valid}, 32'd0);
      chk("rst_rsp_result", h.rsp_result, 32'd0);
      chk("rst_op1", h.op1, 32'd0);
      chk("rst_op_count", {16'b0, op_count}, 32'd0);
      n_rst = 1'b1;
      @(negedge clk);
      chk("cmd_ready_after_rst", {31'b0, h.cmd_ready}, 32'd1);

      // MIN_LAT=3 instance: capture on the third WAIT cycle, i.e. rsp_valid at T+5.
      h3.cmd_op1 = 32'h3F80_0000;
      h3.cmd_op2 = 32'h4000_0000;
      h3.cmd_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      h3.cmd_valid = 1'b0;
      n = 1;
      while (!h3.rsp_valid && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("minlat_latency", n, 5);
      chk("minlat_result", h3.rsp_result, 32'h1234_5678);
      chk("minlat_overflow", {31'b0, h3.rsp_overflow}, 32'd1);
      @(negedge clk);
      chk("minlat_op_count", {16'b0, op_count3}, 32'd1);

      do_op(32'h3FA0_0000, 32'h3FC0_0000, 1'b0, 0, 0);
      do_op(32'h0000_0000, 32'h4000_0000, 1'b1, 0, 0);
      do_op(32'h3F80_0000, 32'h4000_0000, 1'b0, 1000, 0);
      do_op(32'h4040_0000, 32'hC000_0000, 1'b1, 2, 10);
      do_op(32'h0000_0000, 32'h8000_0000, 1'b0, 0, 1);
      do_op(32'h4120_0000, 32'h0001_2345, 1'b1, 0, 0);
      do_op(32'h3F80_0000, 32'h3F80_0000, 1'b0, int'(TMO) - 1, 0);

      for (int i = 0; i < 24; i++) begin
         a = $urandom;
         b = $urandom;
         if ($urandom_range(0, 3) == 0) a[30:23] = 8'h00;
         if ($urandom_range(0, 3) == 0) b[30:23] = 8'h00;
         do_op(a, b, 1'($urandom_range(0, 1)),
               ($urandom_range(0, 5) == 0) ? 40 : int'($urandom_range(0, 4)),
               int'($urandom_range(0, 3)));
      end

      // Abort an operation stuck in WAIT with an asynchronous reset.
      eng_delay = 1000;
      @(negedge clk);
      h.cmd_op1 = 32'h3F80_0000;
      h.cmd_op2 = 32'h4000_0000;
      h.cmd_mode = 1'b0;
      h.cmd_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      h.cmd_valid = 1'b0;
      repeat (5) @(negedge clk);
      #1 n_rst = 1'b0;
      #1;
      chk("abort_cmd_ready", {31'b0, h.cmd_ready}, 32'd0);
      chk("abort_add_start", {31'b0, h.add_start}, 32'd0);
      chk("abort_rsp_valid", {31'b0, h.rsp_valid}, 32'd0);
      chk("abort_op1", h.op1, 32'd0);
      chk("abort_op_count", {16'b0, op_count}, 32'd0);
      exp_cnt = 0;
      @(negedge clk);
      n_rst = 1'b1;
      do_op(32'h3FA0_0000, 32'h3FC0_0000, 1'b0, 1, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
